// File: rtl/adc_sample_writer.sv
// Buffers ADC samples in a small FIFO and writes them to consecutive SDRAM
// word addresses through a Req/Ack/Busy controller handshake.
module adc_sample_writer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] Count,
    input  logic [DATA_W-1:0] SampleIn,
    input  logic              SampleValid,
    output logic [DATA_W-1:0] DataOut,
    output logic [ADDR_W-1:0] Address,
    output logic              Req,
    output logic              WnR,
    input  logic              Busy,
    input  logic              Ack,
    output logic              Active,
    output logic              Done,
    output logic              Overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] accept_left_q, accept_left_d;
    logic [ADDR_W-1:0] write_left_q, write_left_d;
    logic              req_q, req_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, push, pop, accepting, start_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign start_ok   = Start && !active_q;
    assign accepting  = SampleValid && active_q && (accept_left_q != '0);

    always_comb begin
        state_d       = state_q;
        data_out_d    = data_out_q;
        address_d     = address_q;
        addr_cnt_d    = addr_cnt_q;
        accept_left_d = accept_left_q;
        write_left_d  = write_left_q;
        req_d         = req_q;
        active_d      = active_q;
        done_d        = 1'b0;
        overflow_d    = overflow_q;
        pop           = 1'b0;
        push          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (!fifo_empty && !Busy) begin
                    data_out_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                    address_d  = addr_cnt_q;
                    req_d      = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (Ack) begin
                    req_d        = 1'b0;
                    pop          = 1'b1;
                    addr_cnt_d   = addr_cnt_q + 1'b1;
                    write_left_d = write_left_q - 1'b1;
                    state_d      = ST_WAIT;
                    if (write_left_q == ADDR_W'(1)) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (!Ack && !Busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = accepting && (!fifo_full || pop);
        if (accepting && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            accept_left_d = accept_left_q - 1'b1;
        end

        if (start_ok) begin
            overflow_d = 1'b0;
            if (Count == '0) begin
                done_d = 1'b1;
            end else begin
                active_d      = 1'b1;
                addr_cnt_d    = StartAddr;
                accept_left_d = Count;
                write_left_d  = Count;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            data_out_q    <= '0;
            address_q     <= '0;
            addr_cnt_q    <= '0;
            accept_left_q <= '0;
            write_left_q  <= '0;
            req_q         <= 1'b0;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            address_q     <= address_d;
            addr_cnt_q    <= addr_cnt_d;
            accept_left_q <= accept_left_d;
            write_left_q  <= write_left_d;
            req_q         <= req_d;
            active_q      <= active_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= SampleIn;
        end
    end

    assign DataOut  = data_out_q;
    assign Address  = address_q;
    assign Req      = req_q;
    assign WnR      = 1'b1;
    assign Active   = active_q;
    assign Done     = done_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// Scoreboard bench for adc_sample_writer with a simple SDRAM controller model
// that acknowledges one cycle after a request and then stays busy briefly.
module tb_adc_sample_writer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 22;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] StartAddr = '0;
    logic [ADDR_W-1:0] Count = '0;
    logic [DATA_W-1:0] SampleIn = '0;
    logic              SampleValid = 1'b0;
    logic [DATA_W-1:0] DataOut;
    logic [ADDR_W-1:0] Address;
    logic              Req;
    logic              WnR;
    logic              Busy = 1'b0;
    logic              Ack = 1'b0;
    logic              Active;
    logic              Done;
    logic              Overflow;

    wr_t expQ[$];
    int  total = 0;
    int  bad = 0;
    int  writesSeen = 0;
    int  doneSeen = 0;
    int  busyViolations = 0;
    int  busyCnt = 0;
    bit  forceBusy = 1'b0;
    bit  holdAck = 1'b0;
    logic reqPrev = 1'b0;

    adc_sample_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Count(Count), .SampleIn(SampleIn), .SampleValid(SampleValid),
        .DataOut(DataOut), .Address(Address), .Req(Req), .WnR(WnR),
        .Busy(Busy), .Ack(Ack), .Active(Active), .Done(Done), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    // Write monitor plus controller model; Busy here still holds the value
    // the DUT saw at the preceding rising edge.
    always @(negedge Clk) begin
        wr_t e;
        if (!Reset_n) begin
            reqPrev = 1'b0;
            Ack     = 1'b0;
            busyCnt = 0;
            Busy    = forceBusy;
        end else begin
            if (Done) doneSeen++;
            if (Req && !reqPrev) begin
                writesSeen++;
                if (Busy) busyViolations++;
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL write_unexpected addr=%h data=%h required=none", Address, DataOut);
                end else begin
                    e = expQ.pop_front();
                    if (Address !== e.addr || DataOut !== e.data) begin
                        bad++;
                        $display("[TB] FAIL write addr=%h data=%h required addr=%h data=%h",
                                 Address, DataOut, e.addr, e.data);
                    end
                end
            end
            reqPrev = Req;
            if (forceBusy) begin
                Busy = 1'b1; Ack = 1'b0; busyCnt = 0;
            end else if (Req && !Ack && !holdAck && busyCnt == 0) begin
                Ack = 1'b1; busyCnt = 3; Busy = 1'b1;
            end else begin
                Ack = 1'b0;
                if (busyCnt > 0) busyCnt--;
                Busy = (busyCnt > 0);
            end
        end
    end

    task automatic pushExp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic doStart(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] c);
        @(negedge Clk);
        StartAddr = a; Count = c; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic sendSample(input logic [DATA_W-1:0] d);
        SampleIn = d; SampleValid = 1'b1;
        @(negedge Clk);
        SampleValid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!(expQ.size() == 0 && !Req && !Active) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        repeat (6) @(negedge Clk);
        total++;
        if (n >= 2000) begin
            bad++;
            $display("[TB] FAIL %s_timeout pending=%0d required=0", tag, expQ.size());
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        total += 7;
        if (Req !== 1'b0)      begin bad++; $display("[TB] FAIL reset_req got=%b want=0", Req); end
        if (Active !== 1'b0)   begin bad++; $display("[TB] FAIL reset_active got=%b want=0", Active); end
        if (Done !== 1'b0)     begin bad++; $display("[TB] FAIL reset_done got=%b want=0", Done); end
        if (Overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", Overflow); end
        if (DataOut !== '0)    begin bad++; $display("[TB] FAIL reset_dataout got=%h want=0", DataOut); end
        if (Address !== '0)    begin bad++; $display("[TB] FAIL reset_address got=%h want=0", Address); end
        if (WnR !== 1'b1)      begin bad++; $display("[TB] FAIL wnr got=%b want=1", WnR); end
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_basic();
        int w0 = writesSeen;
        int d0 = doneSeen;
        doStart(22'h000100, 22'd4);
        for (int i = 0; i < 4; i++) begin
            pushExp(22'h000100 + ADDR_W'(i), 16'hA001 + DATA_W'(i));
            sendSample(16'hA001 + DATA_W'(i));
        end
        waitIdle("basic");
        total += 4;
        if (writesSeen - w0 != 4) begin bad++; $display("[TB] FAIL basic_writes got=%0d want=4", writesSeen - w0); end
        if (doneSeen - d0 != 1)   begin bad++; $display("[TB] FAIL basic_done got=%0d want=1", doneSeen - d0); end
        if (Overflow !== 1'b0)    begin bad++; $display("[TB] FAIL basic_overflow got=%b want=0", Overflow); end
        if (Active !== 1'b0)      begin bad++; $display("[TB] FAIL basic_active got=%b want=0", Active); end
    endtask

    task automatic test_wrap();
        int d0 = doneSeen;
        logic [ADDR_W-1:0] a;
        doStart(22'h3FFFFE, 22'd3);
        for (int i = 0; i < 3; i++) begin
            a = 22'h3FFFFE + ADDR_W'(i);
            pushExp(a, 16'hB001 + DATA_W'(i));
            sendSample(16'hB001 + DATA_W'(i));
        end
        waitIdle("wrap");
        total++;
        if (doneSeen - d0 != 1) begin bad++; $display("[TB] FAIL wrap_done got=%0d want=1", doneSeen - d0); end
    endtask

    task automatic test_overflow();
        int w0 = writesSeen;
        int d0 = doneSeen;
        int n = 0;
        forceBusy = 1'b1;
        @(negedge Clk);
        doStart(22'h000200, 22'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) pushExp(22'h000200 + ADDR_W'(i), 16'hE000 + DATA_W'(i));
            sendSample(16'hE000 + DATA_W'(i));
        end
        repeat (88) @(negedge Clk);
        total += 2;
        if (writesSeen != w0)  begin bad++; $display("[TB] FAIL busy_hold_writes got=%0d want=0", writesSeen - w0); end
        if (Overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow_set got=%b want=1", Overflow); end
        forceBusy = 1'b0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        repeat (6) @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            pushExp(22'h000208 + ADDR_W'(i), 16'hE00A + DATA_W'(i));
            sendSample(16'hE00A + DATA_W'(i));
        end
        waitIdle("overflow");
        total += 4;
        if (writesSeen - w0 != 10) begin bad++; $display("[TB] FAIL overflow_writes got=%0d want=10", writesSeen - w0); end
        if (doneSeen - d0 != 1)    begin bad++; $display("[TB] FAIL overflow_done got=%0d want=1", doneSeen - d0); end
        if (Overflow !== 1'b1)     begin bad++; $display("[TB] FAIL overflow_sticky got=%b want=1", Overflow); end
        if (busyViolations != 0)   begin bad++; $display("[TB] FAIL req_while_busy got=%0d want=0", busyViolations); end
    endtask

    task automatic test_count_limit();
        int w0 = writesSeen;
        int d0 = doneSeen;
        doStart(22'h000040, 22'd2);
        total++;
        if (Overflow !== 1'b0) begin bad++; $display("[TB] FAIL start_clears_overflow got=%b want=0", Overflow); end
        for (int i = 0; i < 5; i++) begin
            if (i < 2) pushExp(22'h000040 + ADDR_W'(i), 16'hC001 + DATA_W'(i));
            sendSample(16'hC001 + DATA_W'(i));
        end
        waitIdle("count_limit");
        total += 3;
        if (writesSeen - w0 != 2) begin bad++; $display("[TB] FAIL limit_writes got=%0d want=2", writesSeen - w0); end
        if (doneSeen - d0 != 1)   begin bad++; $display("[TB] FAIL limit_done got=%0d want=1", doneSeen - d0); end
        if (Overflow !== 1'b0)    begin bad++; $display("[TB] FAIL limit_overflow got=%b want=0", Overflow); end
    endtask

    task automatic test_count_zero();
        int w0 = writesSeen;
        int d0 = doneSeen;
        doStart(22'h000055, 22'd0);
        total += 2;
        if (Done !== 1'b1)   begin bad++; $display("[TB] FAIL zero_done_pulse got=%b want=1", Done); end
        if (Active !== 1'b0) begin bad++; $display("[TB] FAIL zero_active got=%b want=0", Active); end
        sendSample(16'h1234);
        total++;
        if (Done !== 1'b0) begin bad++; $display("[TB] FAIL zero_done_width got=%b want=0", Done); end
        repeat (10) @(negedge Clk);
        total += 2;
        if (writesSeen != w0)   begin bad++; $display("[TB] FAIL zero_writes got=%0d want=0", writesSeen - w0); end
        if (doneSeen - d0 != 1) begin bad++; $display("[TB] FAIL zero_done_count got=%0d want=1", doneSeen - d0); end
    endtask

    task automatic test_reset_in_req();
        int n = 0;
        int w0;
        holdAck = 1'b1;
        doStart(22'h000300, 22'd2);
        pushExp(22'h000300, 16'hD001);
        sendSample(16'hD001);
        while (Req !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (n >= 50) begin bad++; $display("[TB] FAIL rst_req_timeout got=%b want=1", Req); end
        #2 Reset_n = 1'b0;
        #1;
        total += 3;
        if (Req !== 1'b0)    begin bad++; $display("[TB] FAIL rst_req_drop got=%b want=0", Req); end
        if (Active !== 1'b0) begin bad++; $display("[TB] FAIL rst_active got=%b want=0", Active); end
        if (Address !== '0)  begin bad++; $display("[TB] FAIL rst_address got=%h want=0", Address); end
        expQ.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        holdAck = 1'b0;
        w0 = writesSeen;
        for (int i = 0; i < 3; i++) sendSample(16'hD002 + DATA_W'(i));
        repeat (10) @(negedge Clk);
        total += 2;
        if (writesSeen != w0) begin bad++; $display("[TB] FAIL rst_no_write got=%0d want=0", writesSeen - w0); end
        if (Active !== 1'b0)  begin bad++; $display("[TB] FAIL rst_still_idle got=%b want=0", Active); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_count_limit();
        test_count_zero();
        test_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_writer.md
ADC_SAMPLE_WRITER -- requirements
Module: adc_sample_writer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the sample and SDRAM data width.
REQ-002 Parameter ADDR_W, default 22, SHALL set the SDRAM word-address width.
REQ-003 Parameter FIFO_DEPTH, default 8 (power of 2), SHALL set the sample buffer depth.
REQ-004 Clk, input, 1: single clock; all logic on rising edge.
REQ-005 Reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Start, input, 1: one-cycle pulse; arms a capture run.
REQ-007 StartAddr, input, ADDR_W: first SDRAM word address of the run, sampled on Start.
REQ-008 Count, input, ADDR_W: number of samples in the run, sampled on Start; 0 means no run.
REQ-009 SampleIn, input, DATA_W: ADC sample.
REQ-010 SampleValid, input, 1: SampleIn is valid this cycle.
REQ-011 DataOut, output, DATA_W: write data to the SDRAM controller DataIn.
REQ-012 Address, output, ADDR_W: write address to the SDRAM controller.
REQ-013 Req, output, 1: write request to the SDRAM controller.
REQ-014 WnR, output, 1: constant 1 (write).
REQ-015 Busy, input, 1: SDRAM controller busy.
REQ-016 Ack, input, 1: SDRAM controller acknowledge.
REQ-017 Active, output, 1: run in progress.
REQ-018 Done, output, 1: one-cycle pulse when the last sample of a run is acknowledged.
REQ-019 Overflow, output, 1: sticky flag, set when a sample is lost.

Function
REQ-020 The FIFO SHALL accept SampleIn only when SampleValid=1, Active=1 and the accepted-sample count is below Count.
REQ-021 A valid sample arriving while the FIFO is full and Active=1 SHALL be dropped and SHALL set Overflow.
REQ-022 Overflow SHALL clear only on reset or on Start.
REQ-023 Samples arriving while Active=0 SHALL be ignored without setting Overflow.
REQ-024 Start while Active=1 SHALL be ignored.
REQ-025 Start with Count=0 SHALL leave Active=0 and SHALL pulse Done on the next cycle.
REQ-026 Write FSM state IDLE: when the FIFO is non-empty and Busy=0, load DataOut (FIFO head) and Address (address counter), assert Req, and go to REQ.
REQ-027 Write FSM state REQ: hold Req, DataOut and Address stable; on Ack=1, deassert Req next cycle, pop the FIFO, increment the address counter, and go to WAIT.
REQ-028 Write FSM state WAIT: return to IDLE only when Ack=0 and Busy=0.
REQ-029 Minimum spacing SHALL be one request per 3 cycles; Req SHALL never be asserted while Busy=1 in IDLE.
REQ-030 The address counter SHALL be ADDR_W bits and SHALL wrap from all-ones to 0 without error.
REQ-031 Simultaneous FIFO push and pop SHALL both succeed, including when the FIFO is full.
REQ-032 When the written count reaches Count, Done SHALL pulse on the cycle after the final Ack, and Active SHALL drop in the same cycle.
REQ-033 Any unreachable FSM encoding SHALL return to IDLE with Req=0.

Reset
REQ-034 Reset_n=0 SHALL asynchronously force:
- FSM to IDLE
- FIFO empty
- Req=0, Active=0, Done=0, Overflow=0
- DataOut=0, Address=0, address counter=0
REQ-035 Reset_n=0 during a pending request SHALL drop Req immediately and discard all buffered samples.
REQ-036 Reset deassertion SHALL be treated as synchronous to Clk; the first request SHALL be no earlier than 2 cycles after deassertion.

Verification
REQ-037 Start with StartAddr=0x000100 and Count=4, then 4 samples 0xA001..0xA004; controller model Acks 1 cycle after Req and stays busy 3 cycles -> writes 0xA001..0xA004 to 0x100..0x103 in order, one Done pulse, Overflow=0.
REQ-038 Start with StartAddr=0x3FFFFE and Count=3 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000.
REQ-039 Busy held high for 100 cycles while 10 samples arrive each cycle (FIFO_DEPTH=8) -> first 8 samples written after Busy drops, Overflow=1, Req never asserted while Busy=1.
REQ-040 Count=2 and 5 samples supplied -> only 2 writes, Done pulse, samples 3-5 ignored, Overflow=0.
REQ-041 Reset_n asserted while in REQ -> Req=0 in the same cycle; after release, no request until a new Start and sample.
REQ-042 Start with Count=0 -> Done pulse one cycle later, Req never asserted, Active=0.
